// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, fetch FSM states and PC constants.
package riscv_pkg;

    localparam int XLEN = 32;

    // Sequential fetch advance in bytes and the power-on PC.
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instructions are word aligned; the low two PC bits are always zero.
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~32'h0000_0003;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr & ~PC_ALIGN_MASK) != '0;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: redirect beats sequential advance, which beats hold.
// With MISALIGN_TRAP_EN a misaligned redirect is rejected, otherwise its target is word aligned.
module pc_next_mux
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_req,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance_req,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect_accept,
    output logic            misalign
);

    logic [XLEN-1:0] target;

    assign target = redirect_pc & PC_ALIGN_MASK;

`ifdef MISALIGN_TRAP_EN
    assign misalign = redirect_req && is_misaligned(redirect_pc);
`else
    assign misalign = 1'b0;
`endif

    assign redirect_accept = redirect_req && !misalign;

    // A rejected redirect still blocks the sequential advance of the same cycle.
    always_comb begin
        next_pc = pc;
        if (redirect_accept) begin
            next_pc = target;
        end else if (advance_req && !redirect_req) begin
            next_pc = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC sequencer and instruction-fetch initiator: BOOT -> FETCH <-> ISSUE over a req/ack memory port.
// Optional macro MISALIGN_TRAP_EN adds the Misalign_Err port and rejects misaligned redirects.
module pc_fetch_sequencer
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Stall,
    input  logic            Redirect_Valid,
    input  logic [XLEN-1:0] Redirect_PC,
    output logic            Imem_Req,
    output logic [XLEN-1:0] Imem_Addr,
    input  logic            Imem_Ack,
    input  logic [XLEN-1:0] Imem_Data,
    output logic            Instr_Valid,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC_Out
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            Misalign_Err
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;

    logic            redirect_req;
    logic            advance_req;
    logic            redirect_accept;
    logic            misalign;

    // Redirects arriving before the first fetch are ignored.
    assign redirect_req = Redirect_Valid && (state_q != BOOT);
    assign advance_req  = (state_q == ISSUE) && !Stall;

    pc_next_mux u_pc_next_mux (
        .pc              (pc_q),
        .redirect_req    (redirect_req),
        .redirect_pc     (Redirect_PC),
        .advance_req     (advance_req),
        .next_pc         (pc_d),
        .redirect_accept (redirect_accept),
        .misalign        (misalign)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect_accept) begin
                    valid_d = 1'b0;
                end else if (!misalign && Imem_Ack) begin
                    instr_d  = Imem_Data;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect_accept) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!misalign && !Stall) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q;

    // One pulse per sampled misaligned redirect.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= misalign;
        end
    end

    assign Misalign_Err = err_q;
`endif

    // Request and address come straight from registered state, so they hold until ack or redirect.
    assign Imem_Req    = (state_q == FETCH);
    assign Imem_Addr   = pc_q;
    assign Instr_Valid = valid_q;
    assign Instr       = instr_q;
    assign PC_Out      = pc_out_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus randomized traffic against a rule-level model.
module tb_pc_fetch_sequencer;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        Stall;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ack;
    logic [31:0] Imem_Data;
    logic        Instr_Valid;
    logic [31:0] Instr;
    logic [31:0] PC_Out;
    logic        err_out;

    int tests_run    = 0;
    int tests_failed = 0;

    pc_fetch_sequencer dut (
        .CLK            (CLK),
        .RST            (RST),
        .Stall          (Stall),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_PC    (Redirect_PC),
        .Imem_Req       (Imem_Req),
        .Imem_Addr      (Imem_Addr),
        .Imem_Ack       (Imem_Ack),
        .Imem_Data      (Imem_Data),
        .Instr_Valid    (Instr_Valid),
        .Instr          (Instr),
        .PC_Out         (PC_Out)
`ifdef MISALIGN_TRAP_EN
        ,
        .Misalign_Err   (err_out)
`endif
    );

`ifndef MISALIGN_TRAP_EN
    assign err_out = 1'b0;
`endif

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: fetch outstanding flag, architectural PC and issued instruction.
    bit        m_boot;
    bit        m_req;
    bit [31:0] m_pc;
    bit        m_valid;
    bit [31:0] m_instr;
    bit [31:0] m_pcout;
    bit        m_err;

    task automatic model_reset();
        m_boot  = 1'b1;
        m_req   = 1'b0;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pcout = 32'h0;
        m_err   = 1'b0;
    endtask

    // One clock edge: apply the architectural rules to the inputs held across it, then settle.
    task automatic tick();
        @(posedge CLK);
        m_err = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
            m_req  = 1'b1;
        end else if (Redirect_Valid && !(TRAP && Redirect_PC[1:0] != 2'b00)) begin
            m_pc    = {Redirect_PC[31:2], 2'b00};
            m_valid = 1'b0;
            m_req   = 1'b1;
        end else if (Redirect_Valid) begin
            m_err = 1'b1;
        end else if (m_req) begin
            if (Imem_Ack) begin
                m_instr = Imem_Data;
                m_pcout = m_pc;
                m_valid = 1'b1;
                m_req   = 1'b0;
            end
        end else if (!Stall) begin
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b0;
            m_req   = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        Stall          = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_PC    = 32'h0;
        Imem_Ack       = 1'b0;
        Imem_Data      = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        #2;
        RST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        #3;
        RST = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({Imem_Req, Imem_Addr, Instr_Valid, Instr, PC_Out, err_out} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_values: req=%b addr=%h valid=%b instr=%h pc_out=%h err=%b, required all zero",
                     Imem_Req, Imem_Addr, Instr_Valid, Instr, PC_Out, err_out);
        end
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h0000_0040;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        tick();
        Redirect_Valid = 1'b0;
        tests_run++;
        if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL boot_ignores_redirect: req=%b addr=%h, required req=1 addr=00000000", Imem_Req, Imem_Addr);
        end
    endtask

    task automatic test_ack_tied_high();
        apply_reset();
        Imem_Ack  = 1'b1;
        Imem_Data = 32'hA000_0000;
        tick();
        tests_run++;
        if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h0 || Instr_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_req: req=%b addr=%h valid=%b, required 1/00000000/0", Imem_Req, Imem_Addr, Instr_Valid);
        end
        tick();
        tests_run++;
        if (Instr_Valid !== 1'b1 || PC_Out !== 32'h0 || Instr !== 32'hA000_0000 || Imem_Req !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_issue: valid=%b pc_out=%h instr=%h req=%b, required 1/00000000/a0000000/0",
                     Instr_Valid, PC_Out, Instr, Imem_Req);
        end
        for (int k = 1; k <= 2; k++) begin
            Imem_Data = 32'hA000_0000 + k;
            tick();
            tests_run++;
            if (Imem_Req !== 1'b1 || Imem_Addr !== 32'(4 * k)) begin
                tests_failed++;
                $display("FAIL seq_addr%0d: req=%b addr=%h, required req=1 addr=%h", k, Imem_Req, Imem_Addr, 32'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_wait_and_stall();
        apply_reset();
        Imem_Ack  = 1'b1;
        Imem_Data = 32'h1111_0000;
        tick();
        tick();
        Imem_Ack = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            Imem_Data = $urandom;
            tick();
            tests_run++;
            if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h4 || Instr_Valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL wait_hold%0d: req=%b addr=%h valid=%b, required 1/00000004/0", k, Imem_Req, Imem_Addr, Instr_Valid);
            end
        end
        Imem_Ack  = 1'b1;
        Imem_Data = 32'hCAFE_0004;
        tick();
        Imem_Data = 32'hDEAD_0008;
        tests_run++;
        if (Instr !== 32'hCAFE_0004 || PC_Out !== 32'h4 || Instr_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_capture: instr=%h pc_out=%h valid=%b, required cafe0004/00000004/1", Instr, PC_Out, Instr_Valid);
        end
        tick();
        tick();
        Stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++;
            if (Instr !== 32'hDEAD_0008 || PC_Out !== 32'h8 || Instr_Valid !== 1'b1 || Imem_Req !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: instr=%h pc_out=%h valid=%b req=%b, required dead0008/00000008/1/0",
                         k, Instr, PC_Out, Instr_Valid, Imem_Req);
            end
        end
        Stall    = 1'b0;
        Imem_Ack = 1'b0;
        tick();
        tests_run++;
        if (Imem_Req !== 1'b1 || Imem_Addr !== 32'hC || Instr_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release: req=%b addr=%h valid=%b, required 1/0000000c/0", Imem_Req, Imem_Addr, Instr_Valid);
        end
    endtask

    task automatic test_redirect();
        // Continues from FETCH at 0xC.
        Imem_Ack       = 1'b1;
        Imem_Data      = 32'hBAD0_BAD0;
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h0000_0100;
        tick();
        Redirect_Valid = 1'b0;
        Imem_Data      = 32'h0100_0100;
        tests_run++;
        if (Instr_Valid !== 1'b0 || Imem_Req !== 1'b1 || Imem_Addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL redirect_drop: valid=%b req=%b addr=%h, required 0/1/00000100", Instr_Valid, Imem_Req, Imem_Addr);
        end
        tick();
        tests_run++;
        if (Instr_Valid !== 1'b1 || PC_Out !== 32'h100 || Instr !== 32'h0100_0100) begin
            tests_failed++;
            $display("FAIL redirect_issue: valid=%b pc_out=%h instr=%h, required 1/00000100/01000100", Instr_Valid, PC_Out, Instr);
        end
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'hFFFF_FFFC;
        tick();
        Redirect_Valid = 1'b0;
        tick();
        tests_run++;
        if (PC_Out !== 32'hFFFF_FFFC || Instr_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_first: pc_out=%h valid=%b, required fffffffc/1", PC_Out, Instr_Valid);
        end
        tick();
        tick();
        tests_run++;
        if (PC_Out !== 32'h0 || Instr_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_second: pc_out=%h valid=%b, required 00000000/1", PC_Out, Instr_Valid);
        end
    endtask

    task automatic test_misalign();
        // Continues from ISSUE with PC_Out 0; stall keeps it there.
        Stall          = 1'b1;
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h0000_0102;
        tick();
        Redirect_Valid = 1'b0;
        tests_run++;
        if (TRAP) begin
            if (err_out !== 1'b1 || Imem_Addr !== 32'h0 || Imem_Req !== 1'b0 || Instr_Valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL misalign_trap: err=%b addr=%h req=%b valid=%b, required 1/00000000/0/1",
                         err_out, Imem_Addr, Imem_Req, Instr_Valid);
            end
        end else begin
            if (Imem_Addr !== 32'h100 || Imem_Req !== 1'b1 || Instr_Valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL misalign_force: addr=%h req=%b valid=%b, required 00000100/1/0", Imem_Addr, Imem_Req, Instr_Valid);
            end
        end
        tick();
        tests_run++;
        if (err_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_pulse_width: err=%b, required 0", err_out);
        end
        Stall = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            Stall          = ($urandom_range(0, 3) == 0);
            Imem_Ack       = ($urandom_range(0, 2) == 0);
            Imem_Data      = $urandom;
            Redirect_Valid = ($urandom_range(0, 9) == 0);
            Redirect_PC    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            tick();
            tests_run++;
            if ({Imem_Req, Imem_Addr, Instr_Valid, Instr, PC_Out, err_out} !==
                {m_req, m_pc, m_valid, m_instr, m_pcout, m_err}) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: req=%b addr=%h valid=%b instr=%h pc_out=%h err=%b, required %b/%h/%b/%h/%h/%b",
                         c, Imem_Req, Imem_Addr, Instr_Valid, Instr, PC_Out, err_out,
                         m_req, m_pc, m_valid, m_instr, m_pcout, m_err);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        Imem_Ack  = 1'b1;
        Imem_Data = 32'h7777_7777;
        tick();
        tick();
        tick();
        Imem_Ack = 1'b0;
        tick();
        tests_run++;
        if (Imem_Req !== 1'b1 || PC_Out !== 32'h0 || Instr_Valid !== 1'b0 || Imem_Addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL async_setup: req=%b addr=%h, required 1/00000004", Imem_Req, Imem_Addr);
        end
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (Imem_Req !== 1'b0 || PC_Out !== 32'h0 || Imem_Addr !== 32'h0 || Instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: req=%b pc_out=%h addr=%h instr=%h, required 0/00000000/00000000/00000000",
                     Imem_Req, PC_Out, Imem_Addr, Instr);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        tick();
        tests_run++;
        if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_restart: req=%b addr=%h, required 1/00000000", Imem_Req, Imem_Addr);
        end
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_ack_tied_high();
        test_wait_and_stall();
        test_redirect();
        test_misalign();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Program-counter sequencer and instruction-fetch initiator for the RISC-V core. It owns the architectural PC, requests instructions from instruction memory over a req/ack handshake, and presents each fetched instruction together with its PC. It supports sequential advance, stall hold and branch/jump redirect. PC_Out drives the PC save register's PC_In, so the save register captures the PC of the instruction currently issued.

## Interface
- RESET_PC, 32'h00000000: PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4: sequential increment in bytes.

- CLK  in  1  system clock, rising-edge active.
- RST  in  1  asynchronous, active-low reset.
- Stall  in  1  downstream not ready; holds the issued instruction.
- Redirect_Valid  in  1  branch/jump taken this cycle.
- Redirect_PC  in  32  target PC for the redirect.
- Imem_Req  out  1  fetch request to instruction memory.
- Imem_Addr  out  32  fetch address; stable while Imem_Req=1.
- Imem_Ack  in  1  memory returns Imem_Data this cycle.
- Imem_Data  in  32  instruction word.
- Instr_Valid  out  1  Instr/PC_Out hold a valid issued instruction.
- Instr  out  32  issued instruction.
- PC_Out  out  32  PC of the issued instruction.
- Misalign_Err  out  1  one-cycle pulse on a rejected redirect; present only with MISALIGN_TRAP_EN.

## Operation
- The FSM has three states: BOOT, FETCH and ISSUE. Internal register PC.
- **BOOT:** entered on reset. Moves to FETCH on the first rising edge after RST goes high.
- **FETCH:**
  - Imem_Req=1 and Imem_Addr=PC.
  - On a cycle with Imem_Ack=1: Instr<=Imem_Data, PC_Out<=PC, Instr_Valid<=1, next state ISSUE.
  - Otherwise the FSM stays in FETCH with Req and Addr unchanged.
- **ISSUE:**
  - Imem_Req=0.
  - Stall=0: PC<=PC+PC_STEP, Instr_Valid<=0, next state FETCH.
  - Stall=1: all outputs hold.
- **Redirect:** Redirect_Valid=1 in FETCH or ISSUE has top priority over Ack and Stall.
  - PC<=Redirect_PC, Instr_Valid<=0, next state FETCH.
  - Imem_Data acked in the same cycle is discarded.
  - Redirect_Valid in BOOT is ignored.
- **Wrap-around:** PC arithmetic is modulo 2^32, so 32'hFFFFFFFC+4 gives 32'h00000000.
- **Handshake rules:**
  - Imem_Ack while Imem_Req=0 is ignored.
  - Once asserted, Imem_Req is never withdrawn before Ack, except on a redirect. On a redirect, Req stays high and Addr changes to the new PC on the next cycle.

## Timing
- **Reset values (asynchronous, immediate on RST=0):**
  - state BOOT, PC=RESET_PC.
  - Imem_Req=0, Imem_Addr=RESET_PC.
  - Instr=0, Instr_Valid=0, PC_Out=RESET_PC, Misalign_Err=0.
- **Fetch latency:**
  - Imem_Req rises one edge after reset release.
  - With zero-wait memory (Ack in the same cycle as Req), Instr_Valid rises on the next edge.
  - Each memory wait cycle adds one cycle.
- **Throughput:** at best one instruction per 2 cycles (FETCH and ISSUE).
- **Redirect:** the new target appears on Imem_Addr the cycle after Redirect_Valid is sampled.
- **Reset mid-operation:** any in-flight fetch is abandoned and outputs return to reset values immediately.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A redirect with Redirect_PC[1:0]!=0 is rejected: PC, state and Instr_Valid are unchanged.
  - Misalign_Err pulses high for exactly one cycle.
- MISALIGN_TRAP_EN undefined:
  - The Misalign_Err port is absent.
  - Redirect_PC[1:0] are forced to 00 and the redirect proceeds.

## Structure
- Shared package riscv_pkg holds:
  - the fetch_state_t enum (BOOT, FETCH, ISSUE);
  - PC_STEP and the default RESET_PC;
  - XLEN=32.
- One sub-module, pc_next_mux: combinational next-PC select with priority redirect, then increment, then hold, plus alignment and misalign detection.

## Test plan
- Reset release with Ack tied high:
  - Imem_Req=1 and Addr=0x0 one edge after release.
  - Instr_Valid=1 and PC_Out=0x0 the next edge.
  - Then Addr=0x4, then Addr=0x8.
- Ack delayed 3 cycles: Req and Addr=0x4 held stable for all 3 cycles; Instr equals the Imem_Data word sampled with Ack.
- Stall=1 for 5 cycles in ISSUE: Instr, PC_Out=0x8 and Instr_Valid held; no Req; fetch of 0xC starts after Stall falls.
- Redirect to 0x100 in the same cycle as Ack:
  - The acked data is dropped and Instr_Valid stays 0.
  - Next Addr=0x100 and the next issued PC_Out=0x100.
- Redirect to 0xFFFFFFFC followed by sequential advance: issued PCs are 0xFFFFFFFC, then 0x00000000.
- Redirect to 0x102:
  - With MISALIGN_TRAP_EN: a single Misalign_Err pulse and PC unchanged.
  - Without: next Addr=0x100.
- RST pulsed low mid-FETCH: Req drops to 0 and PC_Out=RESET_PC immediately, without waiting for a clock edge.
